// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared state encoding and protocol constants for the sensor poll scheduler
package sensor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        RX_DATA,
        RX_CRC,
        CHECK,
        RECOVER
    } poll_state_t;

    localparam logic [7:0] CRC_POLY   = 8'h07;
    localparam logic [7:0] ALARM_CODE = 8'hFF;

endpackage

// File: rtl/crc8_calc.sv
// rtl/crc8_calc.sv - combinational CRC-8 over one byte, init 0x00, MSB first, no reflection
module crc8_calc
    import sensor_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] crc
);

    always_comb begin
        crc = data;
        for (int i = 0; i < 8; i++) begin
            crc = crc[7] ? ((crc << 1) ^ CRC_POLY) : (crc << 1);
        end
    end

endmodule

// File: rtl/sensor_poll_scheduler.sv
// rtl/sensor_poll_scheduler.sv - round-robin UART sensor poller with CRC check, retry and fault tracking
// Define SENSOR_POLL_TIMEOUT_EN to treat a silent sensor (no byte within TIMEOUT_CYCLES) as a failed attempt.
module sensor_poll_scheduler
    import sensor_pkg::*;
#(
    parameter int NUM_SENSORS    = 5,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        chip_select,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  tx_data,
    output logic        tx_wr_en,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        rx_rdy_clr
);

    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    poll_state_t   state;
    logic [2:0]    cur_id;
    logic          ctrl_en;
    logic [RW-1:0] retry_cnt;
    logic [6:0]    fault;
    logic          valid;
    logic          alarm;
    logic [7:0]    data_byte;
    logic [7:0]    crc_byte;
    logic [7:0]    smp_data;
    logic [7:0]    smp_crc;
    logic [2:0]    smp_id;
    logic [7:0]    calc_crc;
    logic          host_wr;
    logic          host_rd;
    logic          rx_take;
    logic          crc_ok;
    logic          tmo_hit;
    logic          attempt_fail;
    logic          last_try;
    logic          all_faulted;
    logic [6:0]    fault_upd;
    logic [3:0]    next_pick;
    logic [3:0]    first_pick;
    logic          unused_wdata;

    // {found, id}: first healthy sensor after cur in round-robin order, cur itself last.
    function automatic logic [3:0] pick_next(input logic [2:0] cur, input logic [6:0] flt);
        logic [3:0] r;
        int         s;
        r = {1'b0, cur};
        for (int k = NUM_SENSORS; k >= 1; k--) begin
            s = (int'(cur) - 1 + k) % NUM_SENSORS;
            if (!flt[3'(s)]) r = {1'b1, 3'(s + 1)};
        end
        return r;
    endfunction

    crc8_calc u_crc8 (
        .data (data_byte),
        .crc  (calc_crc)
    );

    assign host_wr      = chip_select & write;
    assign host_rd      = chip_select & read;
    // rx_rdy is still high in the cycle our clear pulse is out; don't take the same byte twice.
    assign rx_take      = rx_rdy & ~rx_rdy_clr;
    assign crc_ok       = (calc_crc == crc_byte);
    assign attempt_fail = ((state == CHECK) && !crc_ok) || tmo_hit;
    assign last_try     = (retry_cnt == RW'(MAX_RETRY - 1));
    assign fault_upd    = fault | ((attempt_fail && last_try) ? (7'd1 << (cur_id - 3'd1)) : 7'd0);
    assign next_pick    = pick_next(cur_id, fault_upd);
    assign first_pick   = pick_next(3'(NUM_SENSORS), fault);
    assign all_faulted  = &fault[NUM_SENSORS-1:0];
    assign unused_wdata = ^writedata[31:2];

    assign readdata = {fault[4:0], (state != IDLE), alarm, valid, 5'b0, smp_id, smp_crc, smp_data};

`ifdef SENSOR_POLL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          in_rx;

    assign in_rx   = (state == RX_DATA) || (state == RX_CRC);
    assign tmo_hit = in_rx && !rx_take && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (in_rx && !rx_take && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cur_id     <= 3'd1;
            ctrl_en    <= 1'b0;
            retry_cnt  <= '0;
            fault      <= '0;
            valid      <= 1'b0;
            alarm      <= 1'b0;
            data_byte  <= '0;
            crc_byte   <= '0;
            smp_data   <= '0;
            smp_crc    <= '0;
            smp_id     <= '0;
            tx_data    <= '0;
            tx_wr_en   <= 1'b0;
            rx_rdy_clr <= 1'b0;
        end else begin
            tx_wr_en   <= 1'b0;
            rx_rdy_clr <= 1'b0;
            if (host_rd) valid <= 1'b0;

            case (state)
                IDLE: if (ctrl_en && !all_faulted) state <= SEND;
                SEND: if (!tx_busy) begin
                    tx_data  <= {5'b0, cur_id};
                    tx_wr_en <= 1'b1;
                    state    <= WAIT_TX;
                end
                WAIT_TX: if (!tx_busy) state <= RX_DATA;
                RX_DATA: if (rx_take) begin
                    data_byte  <= rx_data;
                    rx_rdy_clr <= 1'b1;
                    state      <= RX_CRC;
                end
                RX_CRC: if (rx_take) begin
                    crc_byte   <= rx_data;
                    rx_rdy_clr <= 1'b1;
                    state      <= CHECK;
                end
                CHECK: if (crc_ok && (data_byte != ALARM_CODE)) begin
                    smp_data  <= data_byte;
                    smp_crc   <= crc_byte;
                    smp_id    <= cur_id;
                    valid     <= 1'b1;
                    retry_cnt <= '0;
                    cur_id    <= next_pick[3] ? next_pick[2:0] : cur_id;
                    state     <= (ctrl_en && next_pick[3]) ? SEND : IDLE;
                end else if (crc_ok) begin
                    alarm     <= 1'b1;
                    retry_cnt <= '0;
                    state     <= RECOVER;
                end
                RECOVER: begin
                    cur_id <= first_pick[3] ? first_pick[2:0] : cur_id;
                    state  <= (ctrl_en && first_pick[3]) ? SEND : IDLE;
                end
                default: state <= IDLE;
            endcase

            if (attempt_fail) begin
                if (last_try) begin
                    fault     <= fault_upd;
                    retry_cnt <= '0;
                    cur_id    <= next_pick[3] ? next_pick[2:0] : cur_id;
                    state     <= (ctrl_en && next_pick[3]) ? SEND : IDLE;
                end else begin
                    retry_cnt <= retry_cnt + 1'b1;
                    state     <= ctrl_en ? SEND : IDLE;
                end
            end

            // Host clear is applied last so it wins over a fault or alarm raised this cycle.
            if (host_wr) begin
                ctrl_en <= writedata[0];
                if (writedata[1]) begin
                    alarm <= 1'b0;
                    fault <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// tb/tb_sensor_poll_scheduler.sv - scoreboard bench for sensor_poll_scheduler with a scripted UART sensor
module tb_sensor_poll_scheduler;

    logic        clock = 1'b0;
    logic        resetn;
    logic        chip_select;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_wr_en;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        rx_rdy_clr;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_tx[$];
    logic [18:0] exp_smp[$];

    initial forever #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    sensor_poll_scheduler #(
        .NUM_SENSORS    (5),
        .TIMEOUT_CYCLES (100),
        .MAX_RETRY      (3)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .chip_select (chip_select),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .tx_data     (tx_data),
        .tx_wr_en    (tx_wr_en),
        .tx_busy     (tx_busy),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .rx_rdy_clr  (rx_rdy_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Bit-serial reference: shift each data bit through the x^8+x^2+x+1 register.
    function automatic logic [7:0] crc8_model(input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic host_write(input logic [31:0] wd);
        chip_select = 1'b1;
        write       = 1'b1;
        writedata   = wd;
        @(negedge clock);
        chip_select = 1'b0;
        write       = 1'b0;
        writedata   = '0;
    endtask

    task automatic host_read(output logic [31:0] rd);
        chip_select = 1'b1;
        read        = 1'b1;
        rd          = readdata;
        @(negedge clock);
        chip_select = 1'b0;
        read        = 1'b0;
    endtask

    task automatic wait_tx();
        int n = 0;
        while (!tx_wr_en && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check_eq("tx_seen", tx_wr_en, 1);
        check_eq("tx_id", tx_data, exp_tx.pop_front());
        tx_busy = 1'b1;
        @(negedge clock);
        check_eq("tx_pulse_len", tx_wr_en, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit collide);
        int n = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!rx_rdy_clr && n < 1000);
        check_eq("rx_clr", rx_rdy_clr, 1);
        rx_rdy = 1'b0;
        if (collide) begin
            chip_select = 1'b1;
            read        = 1'b1;
        end
        @(negedge clock);
        check_eq("rx_clr_len", rx_rdy_clr, 0);
        chip_select = 1'b0;
        read        = 1'b0;
    endtask

    task automatic reply(input logic [2:0] id, input logic [7:0] d, input bit bad, input bit collide);
        logic [7:0] c;
        bit         good_sample;
        c = crc8_model(d) ^ (bad ? 8'h5A : 8'h00);
        good_sample = !bad && (d != 8'hFF);
        if (good_sample) exp_smp.push_back({id, c, d});
        @(negedge clock);
        tx_busy = 1'b0;
        send_byte(d, 1'b0);
        send_byte(c, collide);
        if (good_sample) begin
            check_eq("valid", readdata[24], 1);
            check_eq("sample", readdata[18:0], exp_smp.pop_front());
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  pat [5];
        int          ids [4];
        int          pulses;
        int          n;

        pat = '{8'h3C, 8'hA5, 8'h00, 8'h7E, 8'hFE};
        ids = '{3, 4, 5, 1};
        chip_select = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        writedata   = '0;
        tx_busy     = 1'b0;
        rx_data     = '0;
        rx_rdy      = 1'b0;
        resetn      = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_readdata", readdata, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_tx_wr_en", tx_wr_en, 0);
        check_eq("rst_rx_rdy_clr", rx_rdy_clr, 0);
        resetn = 1'b1;
        @(negedge clock);

        // single poll, then sensors 2..5 and wrap back to 1
        host_write(32'h1);
        exp_tx.push_back(8'h01);
        wait_tx();
        reply(3'd1, pat[0], 1'b0, 1'b0);
        check_eq("busy", readdata[26], 1);
        for (int i = 1; i < 5; i++) begin
            exp_tx.push_back(8'(i + 1));
            wait_tx();
            reply(3'(i + 1), pat[i], 1'b0, 1'b0);
        end

        host_read(rd);
        check_eq("rd_valid", rd[24], 1);
        check_eq("rd_clears_valid", readdata[24], 0);

        // host read lands in the same cycle as the new sample
        exp_tx.push_back(8'h01);
        wait_tx();
        reply(3'd1, 8'h5A, 1'b0, 1'b1);
        host_read(rd);
        check_eq("collide_valid", rd[24], 1);

        // three bad CRCs fault sensor 2, which is then skipped
        for (int i = 0; i < 3; i++) begin
            exp_tx.push_back(8'h02);
            wait_tx();
            reply(3'd2, 8'h99, 1'b1, 1'b0);
        end
        check_eq("fault2", readdata[31:27], 5'b00010);
        for (int i = 0; i < 4; i++) begin
            exp_tx.push_back(8'(ids[i]));
            wait_tx();
            reply(3'(ids[i]), 8'(8'h10 + i), 1'b0, 1'b0);
        end

        // alarm reply restarts the sweep at sensor 1
        exp_tx.push_back(8'h03);
        wait_tx();
        reply(3'd3, 8'hFF, 1'b0, 1'b0);
        check_eq("alarm", readdata[25], 1);
        host_write(32'h3);
        check_eq("alarm_clr", readdata[25], 0);
        check_eq("fault_clr", readdata[31:27], 0);
        exp_tx.push_back(8'h01);
        wait_tx();
        reply(3'd1, 8'h24, 1'b0, 1'b0);

        // disable mid-transaction: transaction completes, then idle
        exp_tx.push_back(8'h02);
        wait_tx();
        host_write(32'h0);
        reply(3'd2, 8'h81, 1'b0, 1'b0);
        check_eq("idle_after_stop", readdata[26], 0);
        pulses = 0;
        repeat (30) begin
            @(negedge clock);
            if (tx_wr_en) pulses++;
        end
        check_eq("no_tx_when_off", pulses, 0);

        // reset while waiting for a byte
        host_write(32'h1);
        exp_tx.push_back(8'h03);
        wait_tx();
        @(negedge clock);
        tx_busy = 1'b0;
        @(negedge clock);
        rx_data = 8'h11;
        rx_rdy  = 1'b1;
        #2 resetn = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clock);
            if (tx_wr_en || rx_rdy_clr) pulses++;
        end
        check_eq("rst_no_pulse", pulses, 0);
        check_eq("rst_mid_readdata", readdata, 0);
        rx_rdy = 1'b0;
        resetn = 1'b1;
        @(negedge clock);
        host_write(32'h1);
        exp_tx.push_back(8'h01);
        wait_tx();
        reply(3'd1, 8'h42, 1'b0, 1'b0);

`ifdef SENSOR_POLL_TIMEOUT_EN
        // silent sensor 2: retransmit after the timeout, fault after the third
        for (int r = 0; r < 3; r++) begin
            exp_tx.push_back(8'h02);
            wait_tx();
            @(negedge clock);
            tx_busy = 1'b0;
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!tx_wr_en && n < 500);
            check_eq("tmo_gap_in_range", (n >= 100 && n <= 106), 1);
        end
        exp_tx.push_back(8'h03);
        wait_tx();
        check_eq("tmo_fault", readdata[31:27], 5'b00010);
`else
        n = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_poll_scheduler.md
SENSOR_POLL_SCHEDULER -- requirements
Module: sensor_poll_scheduler

Interface
REQ-001 SHALL have parameter NUM_SENSORS, default 5, meaning number of polled sensors, with IDs 1..NUM_SENSORS and a maximum of 7.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning clock cycles to wait for each received byte.
REQ-003 SHALL have parameter MAX_RETRY, default 3, meaning the number of retries before a sensor is marked faulty.
REQ-004 SHALL have port clock, input, 1 bit, the system clock; all logic is rising-edge.
REQ-005 SHALL have port resetn, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 SHALL have ports chip_select, read and write, each input, 1 bit: host bus strobes.
REQ-007 SHALL have port writedata, input, 32 bits: host control word.
REQ-008 SHALL have port readdata, output, 32 bits: host status word.
REQ-009 SHALL have ports tx_data, output, 8 bits; tx_wr_en, output, 1 bit; and tx_busy, input, 1 bit: the UART transmit side.
REQ-010 SHALL have ports rx_data, input, 8 bits; rx_rdy, input, 1 bit; and rx_rdy_clr, output, 1 bit: the UART receive side.

Function
REQ-011 SHALL use the FSM states IDLE, SEND, WAIT_TX, RX_DATA, RX_CRC, CHECK and RECOVER.
REQ-012 SHALL leave IDLE for SEND when ctrl_en=1, where ctrl_en is written by a host write (chip_select&write) from writedata[0].
REQ-013 SHALL, in SEND when tx_busy=0, drive tx_data={5'b0, cur_id} and pulse tx_wr_en for exactly 1 cycle, then go to WAIT_TX.
REQ-014 SHALL go from WAIT_TX to RX_DATA on the first cycle in which tx_busy=0.
REQ-015 SHALL, in RX_DATA or RX_CRC on rx_rdy=1, latch rx_data into the data or CRC byte, pulse rx_rdy_clr for 1 cycle, and advance to the next state.
REQ-016 SHALL, in CHECK, compute CRC-8 (polynomial 0x07, init 0x00) over the data byte and compare it with the received CRC byte in the same cycle.
REQ-017 SHALL, on a CRC match with data≠0xFF, update the sample register, set valid=1, clear the retry count, advance cur_id and go to SEND, or to IDLE if ctrl_en=0.
REQ-018 SHALL, on a CRC match with data=0xFF (alarm), set alarm=1 and go to RECOVER.
REQ-019 SHALL, in RECOVER, set cur_id=1 and go to SEND after 1 cycle.
REQ-020 SHALL, on a CRC mismatch, increment the retry count and re-enter SEND for the same cur_id.
REQ-021 SHALL advance cur_id as 1→2→…→NUM_SENSORS→1, with wrap-around from NUM_SENSORS to 1.
REQ-022 SHALL, when the retry count reaches MAX_RETRY, set fault[cur_id-1], clear the retry count and advance cur_id.
REQ-023 SHALL skip faulted sensors when advancing cur_id, and hold in IDLE if every sensor is faulted.
REQ-024 SHALL format readdata as: [7:0] data, [15:8] crc, [18:16] id, [24] valid, [25] alarm, [26] busy (state≠IDLE), [31:27] fault[4:0].
REQ-025 SHALL clear valid on a host read (chip_select&read); when a new sample lands in the same cycle, valid SHALL stay 1.
REQ-026 SHALL clear alarm and all fault bits when a host write has writedata[1]=1.
REQ-027 SHALL, when ctrl_en is cleared mid-transaction, finish the current transaction and then go to IDLE.

Reset
REQ-028 SHALL, on reset, set: state=IDLE, cur_id=1, ctrl_en=0, retry count=0, readdata=0, tx_data=0, tx_wr_en=0 and rx_rdy_clr=0.
REQ-029 SHALL, on reset asserted mid-transaction, abandon the transaction immediately, with no tx_wr_en or rx_rdy_clr pulse emitted afterwards.

Configuration
REQ-030 SHALL, with macro SENSOR_POLL_TIMEOUT_EN defined, count cycles in RX_DATA and RX_CRC; reaching TIMEOUT_CYCLES without rx_rdy SHALL count as a retry per REQ-020 and REQ-022.
REQ-031 SHALL, without SENSOR_POLL_TIMEOUT_EN, wait indefinitely in RX_DATA and RX_CRC and contain no timeout counter logic.

Structure
REQ-032 SHALL take the state encoding, CRC polynomial 0x07 and alarm code 0xFF from shared package sensor_pkg.
REQ-033 SHALL implement the CRC-8 computation as the combinational sub-module crc8_calc.

Verification
REQ-034 SHALL check a single poll: ctrl_en=1, sensor 1 replies 0x3C plus its correct CRC → readdata[18:16]=1, [7:0]=0x3C, valid=1, next tx_data=0x02.
REQ-035 SHALL check wrap-around: 5 good replies → sixth tx_data=0x01.
REQ-036 SHALL check CRC error: 3 bad-CRC replies from sensor 2 → fault[1]=1, and subsequent polls skip ID 2.
REQ-037 SHALL check alarm: data 0xFF with correct CRC → alarm=1, next tx_data=0x01.
REQ-038 SHALL check timeout (SENSOR_POLL_TIMEOUT_EN, TIMEOUT_CYCLES=100): no reply → retransmission after 100 cycles, and fault set after 3 retries.
REQ-039 SHALL check read/update collision: host read in the same cycle a sample lands → valid remains 1.
